// File: rtl/tail_light_seq.sv
// Tail-light sequencer: eight switch-selected lighting modes on a symmetric LED bar,
// two indicator lamps and a two-digit multiplexed hex display of mode and step.
module tail_light_seq #(
  parameter int unsigned LEDS_PER_SIDE = 4,
  parameter int unsigned STEP_DIV      = 12500000,
  parameter int unsigned SCAN_DIV      = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   sw,
  output logic [2*LEDS_PER_SIDE-1:0]   led,
  output logic                         led_l,
  output logic                         led_r,
  output logic [7:0]                   digit_seg,
  output logic [1:0]                   digit_cath
);

  localparam int unsigned N    = LEDS_PER_SIDE;
  localparam int          Nint = int'(LEDS_PER_SIDE);
  localparam int unsigned PW   = $clog2(STEP_DIV);
  localparam int unsigned SW   = $clog2(SCAN_DIV);

  localparam logic [PW-1:0] PresLast = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    TurnLast = 4'(N);
  localparam logic [N-1:0]  HalfOff  = '0;
  localparam logic [N-1:0]  HalfOn   = '1;

  typedef enum logic [2:0] {
    ModeOff, ModeLeft, ModeRight, ModeHazard,
    ModeBrake, ModeBrakeLeft, ModeBrakeRight, ModeFault
  } mode_e;

  logic [2:0]        sw_meta_q, sw_s_q;
  mode_e             mode_q, mode_d, mode_in;
  logic [3:0]        step_q, step_d, step_last;
  logic [PW-1:0]     pres_q, pres_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic              sel_q, sel_d;
  logic [2*N-1:0]    led_q, led_d;
  logic              led_l_q, led_l_d, led_r_q, led_r_d;
  logic [7:0]        seg_q, seg_d;
  logic [N-1:0]      left_bar, right_bar;

  function automatic logic [7:0] hex_font(input logic [3:0] v);
    logic [7:0] f;
    case (v)
      4'h0: f = 8'b1111_1100;
      4'h1: f = 8'b0110_0000;
      4'h2: f = 8'b1101_1010;
      4'h3: f = 8'b1111_0010;
      4'h4: f = 8'b0110_0110;
      4'h5: f = 8'b1011_0110;
      4'h6: f = 8'b1011_1110;
      4'h7: f = 8'b1110_0000;
      4'h8: f = 8'b1111_1110;
      4'h9: f = 8'b1111_0110;
      4'ha: f = 8'b1110_1110;
      4'hb: f = 8'b0011_1110;
      4'hc: f = 8'b1001_1100;
      4'hd: f = 8'b0111_1010;
      4'he: f = 8'b1001_1110;
      default: f = 8'b1000_1110;
    endcase
    return f;
  endfunction

  assign mode_in = mode_e'(sw_s_q);

  always_comb begin
    step_last = 4'd1;
    if (mode_q == ModeLeft || mode_q == ModeRight ||
        mode_q == ModeBrakeLeft || mode_q == ModeBrakeRight) begin
      step_last = TurnLast;
    end
  end

  // A mode change restarts the animation; the clear beats a coincident tick.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    pres_d = pres_q + PW'(1);
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      step_d = '0;
      pres_d = '0;
    end else if (pres_q == PresLast) begin
      pres_d = '0;
      step_d = (step_q == step_last) ? 4'd0 : step_q + 4'd1;
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    sel_d  = sel_q;
    if (scan_q == ScanLast) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
  end

  // Left turn fills outward from the bar centre (low bits of the left half),
  // right turn fills outward from the centre (high bits of the right half).
  always_comb begin
    left_bar  = '0;
    right_bar = '0;
    for (int i = 0; i < Nint; i++) begin
      left_bar[i]  = (i < int'(step_q));
      right_bar[i] = (i >= Nint - int'(step_q));
    end
  end

  always_comb begin
    led_d   = '0;
    led_l_d = 1'b0;
    led_r_d = 1'b0;
    case (mode_q)
      ModeLeft: begin
        led_d   = {left_bar, HalfOff};
        led_l_d = (step_q != 4'd0);
      end
      ModeRight: begin
        led_d   = {HalfOff, right_bar};
        led_r_d = (step_q != 4'd0);
      end
      ModeHazard: begin
        led_d   = (step_q == 4'd0) ? {HalfOn, HalfOn} : {HalfOff, HalfOff};
        led_l_d = (step_q == 4'd0);
        led_r_d = (step_q == 4'd0);
      end
      ModeBrake: led_d = {HalfOn, HalfOn};
      ModeBrakeLeft: begin
        led_d   = {left_bar, HalfOn};
        led_l_d = (step_q != 4'd0);
      end
      ModeBrakeRight: begin
        led_d   = {HalfOn, right_bar};
        led_r_d = (step_q != 4'd0);
      end
      ModeFault: begin
        led_l_d = (step_q == 4'd0);
        led_r_d = (step_q == 4'd1);
      end
      default: ;
    endcase
  end

  // Segments use the next digit select so they switch on the same edge as the cathodes.
  assign seg_d = hex_font(sel_d ? step_q : {1'b0, mode_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      mode_q    <= ModeOff;
      step_q    <= '0;
      pres_q    <= '0;
      scan_q    <= '0;
      sel_q     <= 1'b0;
      led_q     <= '0;
      led_l_q   <= 1'b0;
      led_r_q   <= 1'b0;
      seg_q     <= 8'b1111_1100;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
      mode_q    <= mode_d;
      step_q    <= step_d;
      pres_q    <= pres_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
      led_q     <= led_d;
      led_l_q   <= led_l_d;
      led_r_q   <= led_r_d;
      seg_q     <= seg_d;
    end
  end

  assign led        = led_q;
  assign led_l      = led_l_q;
  assign led_r      = led_r_q;
  assign digit_seg  = seg_q;
  assign digit_cath = sel_q ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_tail_light_seq.sv
// Randomised scoreboard bench for tail_light_seq: a timing-level reference model queues the
// expected outputs for every cycle and a monitor compares them on the falling clock edge.
module tb_tail_light_seq;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw  = 3'd3;
  logic [7:0] led;
  logic       led_l, led_r;
  logic [7:0] digit_seg;
  logic [1:0] digit_cath;

  tail_light_seq #(
    .LEDS_PER_SIDE(N),
    .STEP_DIV     (SD),
    .SCAN_DIV     (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .led       (led),
    .led_l     (led_l),
    .led_r     (led_r),
    .digit_seg (digit_seg),
    .digit_cath(digit_cath)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic       l;
    logic       r;
    logic [7:0] seg;
    logic [1:0] cath;
  } exp_t;

  logic [7:0] font_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  function automatic bit is_turn(input int m);
    return (m == 1 || m == 2 || m == 5 || m == 6);
  endfunction

  // Step = number of whole prescaler periods since the last restart, modulo cycle length.
  function automatic int step_of(input int m, input int since);
    int len;
    len = is_turn(m) ? N + 1 : 2;
    return (since / SD) % len;
  endfunction

  function automatic logic [7:0] led_of(input int m, input int s);
    int full, lm, rm;
    full = (1 << N) - 1;
    lm   = (1 << s) - 1;
    rm   = lm << (N - s);
    case (m)
      1:       return 8'(lm << N);
      2:       return 8'(rm);
      3:       return (s == 0) ? 8'hFF : 8'h00;
      4:       return 8'hFF;
      5:       return 8'((lm << N) | full);
      6:       return 8'((full << N) | rm);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic l_of(input int m, input int s);
    if (m == 1 || m == 5) return s != 0;
    if (m == 3 || m == 7) return s == 0;
    return 1'b0;
  endfunction

  function automatic logic r_of(input int m, input int s);
    if (m == 2 || m == 6) return s != 0;
    if (m == 3)           return s == 0;
    if (m == 7)           return s == 1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Reference model: mode is sw seen two edges earlier; timing is counted in whole cycles.
  initial begin : model
    int   hist [3];
    int   mode_m, since, cycles, pm, ps, sel;
    exp_t e;
    hist   = '{0, 0, 0};
    mode_m = 0;
    since  = 0;
    cycles = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        hist   = '{0, 0, 0};
        mode_m = 0;
        since  = 0;
        cycles = 0;
        sb_q.delete();
        e = '{led: 8'h00, l: 1'b0, r: 1'b0, seg: 8'hFC, cath: 2'b10};
        sb_q.push_back(e);
      end else begin
        pm      = mode_m;
        ps      = step_of(mode_m, since);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int'(sw);
        if (hist[2] != mode_m) begin
          mode_m = hist[2];
          since  = 0;
        end else begin
          since++;
        end
        cycles++;
        sel = (cycles / SC) % 2;
        e.led  = led_of(pm, ps);
        e.l    = l_of(pm, ps);
        e.r    = r_of(pm, ps);
        e.seg  = font_tab[(sel == 1) ? ps : pm];
        e.cath = (sel == 1) ? 2'b01 : 2'b10;
        sb_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("led",        led,               e.led);
        check("led_l",      {7'd0, led_l},     {7'd0, e.l});
        check("led_r",      {7'd0, led_r},     {7'd0, e.r});
        check("digit_seg",  digit_seg,         e.seg);
        check("digit_cath", {6'd0, digit_cath}, {6'd0, e.cath});
      end
    end
  end

  task automatic hold_sw(input int m, input int cyc);
    sw = 3'(m);
    repeat (cyc) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset(input int cyc);
    rst = 1'b0;
    repeat (cyc) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin : stimulus
    int m, c;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    hold_sw(3, 20);
    hold_sw(1, 30);
    hold_sw(2, 30);
    hold_sw(5, 30);
    hold_sw(1, 3 + 3 * SD + 1);
    hold_sw(6, 30);
    hold_sw(3, 20);
    hold_sw(7, 20);
    hold_sw(4, 12);
    hold_sw(0, 12);
    for (int k = 0; k < 60; k++) begin
      m = int'($urandom_range(0, 7));
      c = int'($urandom_range(1, 40));
      hold_sw(m, c);
      if ($urandom_range(0, 9) == 0) pulse_reset(int'($urandom_range(1, 4)));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (checks < 500) begin
      failures++;
      $display("FAIL too_few_checks got=%0d want>=500", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
